// File: rtl/multi_bit_change_detector.sv
// multi_bit_change_detector: per-channel Mealy change detection with registered flags, saturating count and sticky event flag
module multi_bit_change_detector #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Mask,
  input  logic [1:0]       Mode,
  input  logic             Cnt_clr,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic [CNT_W-1:0] Cnt,
  output logic             Any
);
  typedef enum logic [1:0] {INIT = 2'd0, ZERO = 2'd1, ONE = 2'd2} state_t;
  state_t st_q [WIDTH];
  state_t st_d [WIDTH];
  logic [WIDTH-1:0] flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic any_q, any_d;
  logic [CNT_W:0] pop, sum;
  // Event flags and next history per channel; encoding 3 matches neither ZERO nor ONE so it behaves as INIT
  always_comb begin
    Y = '0;
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      st_d[i] = Clr ? INIT : En ? (X[i] ? ONE : ZERO) : st_q[i];
      Y[i] = En & Mask[i] & ~Clr & (((st_q[i] == ZERO) & X[i] & ~Mode[1]) | ((st_q[i] == ONE) & ~X[i] & ~Mode[0]));
      pop = pop + (CNT_W+1)'(Y[i]);
    end
    sum = {1'b0, cnt_q} + pop;
    flag_d = Clr ? '0 : Y;
    cnt_d = (Clr | Cnt_clr) ? '0 : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    any_d = (Clr | Cnt_clr) ? 1'b0 : any_q | (|Y);
  end
  // Register channel history, delayed flags, counter and sticky flag
  always_ff @(posedge Clk) begin
    st_q <= st_d;
    flag_q <= flag_d;
    cnt_q <= cnt_d;
    any_q <= any_d;
  end
  assign Y_q = flag_q;
  assign Cnt = cnt_q;
  assign Any = any_q;
endmodule

// File: tb/tb_multi_bit_change_detector.sv
// tb_multi_bit_change_detector: directed scoreboard bench for multi_bit_change_detector
module tb_multi_bit_change_detector;
  logic Clk = 1'b0;
  logic Clr = 1'b1, En = 1'b0, Cnt_clr = 1'b0;
  logic [3:0] X = '0, Mask = '0, Y, Y_q, Cnt;
  logic [1:0] Mode = '0;
  logic Any;
  int checks = 0, failures = 0;
  typedef struct {
    logic [3:0] y;
    logic [3:0] cnt;
    logic any;
    int id;
  } exp_t;
  exp_t q[$];

  multi_bit_change_detector #(.WIDTH(4), .CNT_W(4)) dut (
    .Clk(Clk), .Clr(Clr), .En(En), .X(X), .Mask(Mask), .Mode(Mode),
    .Cnt_clr(Cnt_clr), .Y(Y), .Y_q(Y_q), .Cnt(Cnt), .Any(Any)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, id, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the expected response
  task automatic step(input int id, input logic clr, input logic en, input logic cc, input logic [3:0] mask,
                      input logic [1:0] mode, input logic [3:0] x, input logic [3:0] ey, input logic [3:0] ecnt,
                      input logic eany);
    exp_t e;
    @(negedge Clk);
    Clr = clr; En = en; Cnt_clr = cc; Mask = mask; Mode = mode; X = x;
    e.y = ey; e.cnt = ecnt; e.any = eany; e.id = id;
    q.push_back(e);
  endtask

  // Monitor: Y checked mid-cycle, registered outputs checked just after the following edge
  initial begin
    exp_t r;
    forever begin
      @(negedge Clk);
      #2;
      if (q.size() != 0) begin
        r = q.pop_front();
        chk("Y", r.id, Y, r.y);
        @(posedge Clk);
        #1;
        chk("Y_q", r.id, Y_q, r.y);
        chk("Cnt", r.id, Cnt, r.cnt);
        chk("Any", r.id, {3'b0, Any}, {3'b0, r.any});
      end
    end
  end

  initial begin
    //   id clr en cc mask    mode   x        Y        Cnt  Any
    step(0,  1, 1, 0, 4'hF,   2'b00, 4'b1010, 4'h0,    4'd0,  0);
    step(1,  0, 1, 0, 4'hF,   2'b00, 4'b1010, 4'h0,    4'd0,  0);
    step(2,  0, 1, 0, 4'hF,   2'b00, 4'b0101, 4'hF,    4'd4,  1);
    step(3,  0, 1, 1, 4'hF,   2'b00, 4'b0011, 4'b0110, 4'd0,  0);
    step(4,  0, 1, 0, 4'hF,   2'b01, 4'b0101, 4'b0100, 4'd1,  1);
    step(5,  0, 1, 0, 4'hF,   2'b11, 4'b0011, 4'h0,    4'd1,  1);
    step(6,  0, 1, 0, 4'hF,   2'b10, 4'b0101, 4'b0010, 4'd2,  1);
    step(7,  0, 1, 0, 4'hF,   2'b11, 4'b0011, 4'h0,    4'd2,  1);
    step(8,  0, 1, 0, 4'hF,   2'b11, 4'b0101, 4'h0,    4'd2,  1);
    step(9,  0, 1, 0, 4'b0001,2'b00, 4'b1010, 4'b0001, 4'd3,  1);
    step(10, 0, 0, 0, 4'hF,   2'b00, 4'b0101, 4'h0,    4'd3,  1);
    step(11, 0, 0, 0, 4'hF,   2'b00, 4'b1111, 4'h0,    4'd3,  1);
    step(12, 0, 1, 0, 4'hF,   2'b00, 4'b0101, 4'hF,    4'd7,  1);
    step(13, 0, 1, 1, 4'hF,   2'b00, 4'b1010, 4'hF,    4'd0,  0);
    step(14, 0, 1, 0, 4'hF,   2'b00, 4'b0101, 4'hF,    4'd4,  1);
    step(15, 0, 1, 1, 4'hF,   2'b00, 4'b1010, 4'hF,    4'd0,  0);
    step(16, 0, 1, 0, 4'hF,   2'b00, 4'b0101, 4'hF,    4'd4,  1);
    step(17, 0, 1, 0, 4'hF,   2'b00, 4'b1010, 4'hF,    4'd8,  1);
    step(18, 0, 1, 0, 4'hF,   2'b00, 4'b0101, 4'hF,    4'd12, 1);
    step(19, 0, 1, 0, 4'hF,   2'b00, 4'b1010, 4'hF,    4'd15, 1);
    step(20, 0, 1, 0, 4'hF,   2'b00, 4'b0101, 4'hF,    4'd15, 1);
    step(21, 1, 1, 0, 4'hF,   2'b00, 4'b1010, 4'h0,    4'd0,  0);
    step(22, 0, 1, 0, 4'hF,   2'b00, 4'b0101, 4'h0,    4'd0,  0);
    step(23, 0, 1, 0, 4'hF,   2'b00, 4'b1010, 4'hF,    4'd4,  1);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge Clk);
    repeat (2) @(negedge Clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
